// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Registered one-hot-opcode ALU with valid/ready handshake, flags,
//            a chained carry and a multi-cycle shift-and-add multiply.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int OPW   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [OPW-1:0]   op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    localparam int             CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_result;
    logic                 r_cout;
    logic                 r_zero;
    logic                 r_ovf;
    logic                 r_err;
    logic                 r_carry;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;

    logic                 w_accept;
    logic                 w_legal;
    logic                 w_is_mul;
    logic                 w_upd_carry;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [WIDTH:0]       w_adc;
    logic [WIDTH-1:0]     w_res;
    logic                 w_cout;
    logic                 w_ovf;
    logic [2*WIDTH-1:0]   w_acc_next;

    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign out_valid = (r_state == S_DONE);
    assign w_accept  = in_valid && in_ready;

    // Legal means exactly one bit set, and that bit within the 12 defined opcodes.
    assign w_legal     = ((op >> 12) == '0) && (op != '0) && ((op & (op - 1'b1)) == '0);
    assign w_is_mul    = w_legal && op[10];
    assign w_upd_carry = w_legal && !(op[6] || op[7] || op[8] || op[9]);

    assign w_sum      = {1'b0, a} + {1'b0, b};
    assign w_diff     = {1'b0, a} - {1'b0, b};
    assign w_adc      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, r_carry};
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_res  = '0;
        w_cout = 1'b0;
        w_ovf  = 1'b0;
        if (w_legal) begin
            if (op[0]) begin
                w_res  = w_sum[WIDTH-1:0];
                w_cout = w_sum[WIDTH];
                w_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end else if (op[1]) begin
                w_res  = w_diff[WIDTH-1:0];
                w_cout = w_diff[WIDTH];
                w_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end else if (op[2]) begin
                w_res  = {a[WIDTH-2:0], cin};
                w_cout = a[WIDTH-1];
            end else if (op[3]) begin
                w_res  = {cin, a[WIDTH-1:1]};
                w_cout = a[0];
            end else if (op[4]) begin
                w_res  = {a[WIDTH-2:0], a[WIDTH-1]};
                w_cout = a[WIDTH-1];
            end else if (op[5]) begin
                w_res  = {a[0], a[WIDTH-1:1]};
                w_cout = a[0];
            end else if (op[6]) begin
                w_res  = ~a;
            end else if (op[7]) begin
                w_res  = a & b;
            end else if (op[8]) begin
                w_res  = a | b;
            end else if (op[9]) begin
                w_res  = a ^ b;
            end else if (op[11]) begin
                w_res  = w_adc[WIDTH-1:0];
                w_cout = w_adc[WIDTH];
                w_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (w_adc[WIDTH-1] != a[WIDTH-1]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state  <= S_BUSY;
                            r_cnt    <= '0;
                            r_acc    <= '0;
                            r_mcand  <= {{WIDTH{1'b0}}, a};
                            r_mplier <= b;
                        end else begin
                            r_state  <= S_DONE;
                            r_result <= w_res;
                            r_cout   <= w_cout;
                            r_ovf    <= w_ovf;
                            r_err    <= !w_legal;
                            r_zero   <= w_legal && (w_res == '0);
                            if (w_upd_carry) begin
                                r_carry <= w_cout;
                            end
                        end
                    end else if (r_state == S_DONE && out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    // The final partial product is folded in on the same edge that completes.
                    if (r_cnt == C_LAST) begin
                        r_state  <= S_DONE;
                        r_result <= w_acc_next[WIDTH-1:0];
                        r_cout   <= |w_acc_next[2*WIDTH-1:WIDTH];
                        r_carry  <= |w_acc_next[2*WIDTH-1:WIDTH];
                        r_zero   <= (w_acc_next[WIDTH-1:0] == '0);
                        r_ovf    <= 1'b0;
                        r_err    <= 1'b0;
                    end else begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign result = r_result;
    assign cout   = r_cout;
    assign zero   = r_zero;
    assign ovf    = r_ovf;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq against an arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int W  = 8;
    localparam int OW = 16;

    localparam logic [15:0] OP_ADD = 16'h0001;
    localparam logic [15:0] OP_SUB = 16'h0002;
    localparam logic [15:0] OP_SHL = 16'h0004;
    localparam logic [15:0] OP_SHR = 16'h0008;
    localparam logic [15:0] OP_ROR = 16'h0020;
    localparam logic [15:0] OP_AND = 16'h0080;
    localparam logic [15:0] OP_OR  = 16'h0100;
    localparam logic [15:0] OP_XOR = 16'h0200;
    localparam logic [15:0] OP_MUL = 16'h0400;
    localparam logic [15:0] OP_ADC = 16'h0800;

    typedef struct {
        logic [15:0] op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        cin;
        logic [7:0]  r;
        logic        c;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic [OW-1:0] op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          cout;
    logic          zero;
    logic          ovf;
    logic          err;

    int   cmp  = 0;
    int   errs = 0;
    logic m_carry;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .OPW(OW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op(op), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .cout(cout), .zero(zero),
        .ovf(ovf), .err(err)
    );

    // Reference: plain integer arithmetic on the opcode's meaning; tracks the carry flag.
    task automatic model(input logic [15:0] mop, input logic [7:0] ma, input logic [7:0] mb,
                         input logic mcin, output logic [7:0] er, output logic ec,
                         output logic ez, output logic ev, output logic ee);
        int ia, ib, sa, sb, s, k, nb;
        ia = int'(ma);
        ib = int'(mb);
        sa = (ia >= 128) ? ia - 256 : ia;
        sb = (ib >= 128) ? ib - 256 : ib;
        nb = 0;
        k  = -1;
        for (int i = 0; i < 16; i++) if (mop[i]) begin nb++; k = i; end
        er = 8'd0; ec = 1'b0; ez = 1'b0; ev = 1'b0; ee = 1'b0;
        if (nb != 1 || k >= 12) begin
            ee = 1'b1;
            return;
        end
        case (k)
            0: begin s = ia + ib; er = 8'(s % 256); ec = (s > 255);
                     ev = (sa + sb > 127) || (sa + sb < -128); end
            1: begin s = ia - ib; er = 8'((s + 256) % 256); ec = (ia < ib);
                     ev = (sa - sb > 127) || (sa - sb < -128); end
            2: begin er = 8'((ia * 2 + int'(mcin)) % 256); ec = (ia >= 128); end
            3: begin er = 8'(ia / 2 + (mcin ? 128 : 0)); ec = (ia % 2 == 1); end
            4: begin er = 8'((ia * 2) % 256 + ia / 128); ec = (ia >= 128); end
            5: begin er = 8'(ia / 2 + (ia % 2) * 128); ec = (ia % 2 == 1); end
            6: er = 8'(255 - ia);
            7: er = ma & mb;
            8: er = ma | mb;
            9: er = ma ^ mb;
            10: begin s = ia * ib; er = 8'(s % 256); ec = (s >= 256); end
            default: begin s = ia + ib + int'(m_carry); er = 8'(s % 256); ec = (s > 255);
                     ev = (sa + sb + int'(m_carry) > 127) || (sa + sb + int'(m_carry) < -128); end
        endcase
        ez = (er == 8'd0);
        if (k <= 5 || k >= 10) m_carry = ec;
    endtask

    // Presents one op (called at posedge+1 with in_ready high), waits for out_valid.
    task automatic run_op(input logic [15:0] o, input logic [7:0] x, input logic [7:0] y,
                          input logic ci, output int lat, output bit rdy_seen);
        in_valid = 1'b1; op = o; a = x; b = y; cin = ci;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 16'($urandom); a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        lat = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; op = '0;
        m_carry = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        cmp++; if (result !== 8'd0) begin errs++; $display("FAIL reset_result: got %0d want 0", result); end
        cmp++; if ({cout, zero, ovf, err} !== 4'b0000) begin errs++; $display("FAIL reset_flags: got %b want 0000", {cout, zero, ovf, err}); end
        cmp++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        cmp++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        vec_t vt[6];
        logic [7:0] er; logic ec, ez, ev, ee;
        int lat; bit rs;
        vt[0] = '{OP_ADD, 8'd100, 8'd100, 1'b0, 8'd200, 1'b0};
        vt[1] = '{OP_SUB, 8'd50,  8'd100, 1'b0, 8'd206, 1'b1};
        vt[2] = '{OP_SHL, 8'd129, 8'd0,   1'b1, 8'h03,  1'b1};
        vt[3] = '{OP_SHR, 8'd129, 8'd0,   1'b0, 8'h40,  1'b1};
        vt[4] = '{OP_ROR, 8'd129, 8'd0,   1'b0, 8'hC0,  1'b1};
        vt[5] = '{OP_XOR, 8'd85,  8'd211, 1'b0, 8'd134, 1'b0};
        for (int i = 0; i < 6; i++) begin
            model(vt[i].op, vt[i].a, vt[i].b, vt[i].cin, er, ec, ez, ev, ee);
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].cin, lat, rs);
            cmp++; if (result !== vt[i].r) begin errs++; $display("FAIL dir%0d_result: got %0d want %0d", i, result, vt[i].r); end
            cmp++; if (cout !== vt[i].c) begin errs++; $display("FAIL dir%0d_cout: got %b want %b", i, cout, vt[i].c); end
            cmp++; if ({zero, ovf, err} !== {ez, ev, ee}) begin errs++; $display("FAIL dir%0d_flags: got %b want %b", i, {zero, ovf, err}, {ez, ev, ee}); end
            cmp++; if (lat != 1) begin errs++; $display("FAIL dir%0d_latency: got %0d want 1", i, lat); end
        end
        // Test-plan ADD 100+100 overflows signed; SUB 50-100 does not.
        model(OP_ADD, 8'd100, 8'd100, 1'b0, er, ec, ez, ev, ee);
        run_op(OP_ADD, 8'd100, 8'd100, 1'b0, lat, rs);
        cmp++; if (ovf !== 1'b1) begin errs++; $display("FAIL add_ovf: got %b want 1", ovf); end
        model(OP_SUB, 8'd50, 8'd100, 1'b0, er, ec, ez, ev, ee);
        run_op(OP_SUB, 8'd50, 8'd100, 1'b0, lat, rs);
        cmp++; if (ovf !== 1'b0) begin errs++; $display("FAIL sub_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_carry_chain;
        logic [7:0] er; logic ec, ez, ev, ee;
        int lat; bit rs;
        model(OP_ADD, 8'd200, 8'd100, 1'b0, er, ec, ez, ev, ee);
        run_op(OP_ADD, 8'd200, 8'd100, 1'b0, lat, rs);
        cmp++; if ({result, cout} !== {8'd44, 1'b1}) begin errs++; $display("FAIL chain_add: got %0d/%b want 44/1", result, cout); end
        model(OP_ADC, 8'd0, 8'd0, 1'b0, er, ec, ez, ev, ee);
        run_op(OP_ADC, 8'd0, 8'd0, 1'b0, lat, rs);
        cmp++; if ({result, cout} !== {8'd1, 1'b0}) begin errs++; $display("FAIL chain_adc: got %0d/%b want 1/0", result, cout); end
        model(OP_AND, 8'hFF, 8'hFF, 1'b0, er, ec, ez, ev, ee);
        run_op(OP_AND, 8'hFF, 8'hFF, 1'b0, lat, rs);
        model(OP_ADC, 8'd0, 8'd0, 1'b0, er, ec, ez, ev, ee);
        run_op(OP_ADC, 8'd0, 8'd0, 1'b0, lat, rs);
        cmp++; if (result !== 8'd0) begin errs++; $display("FAIL chain_and_keeps0: got %0d want 0", result); end
        model(OP_ADD, 8'd200, 8'd100, 1'b0, er, ec, ez, ev, ee);
        run_op(OP_ADD, 8'd200, 8'd100, 1'b0, lat, rs);
        model(OP_AND, 8'h0F, 8'h0F, 1'b0, er, ec, ez, ev, ee);
        run_op(OP_AND, 8'h0F, 8'h0F, 1'b0, lat, rs);
        model(OP_ADC, 8'd0, 8'd0, 1'b0, er, ec, ez, ev, ee);
        run_op(OP_ADC, 8'd0, 8'd0, 1'b0, lat, rs);
        cmp++; if (result !== 8'd1) begin errs++; $display("FAIL chain_and_keeps1: got %0d want 1", result); end
    endtask

    task automatic test_illegal;
        logic [15:0] ill[3];
        logic [7:0] er; logic ec, ez, ev, ee;
        int lat; bit rs;
        ill[0] = 16'h0000; ill[1] = 16'h0003; ill[2] = 16'h1000;
        for (int i = 0; i < 3; i++) begin
            model(OP_ADD, 8'd255, 8'd1, 1'b0, er, ec, ez, ev, ee);
            run_op(OP_ADD, 8'd255, 8'd1, 1'b0, lat, rs);
            model(ill[i], 8'd7, 8'd9, 1'b1, er, ec, ez, ev, ee);
            run_op(ill[i], 8'd7, 8'd9, 1'b1, lat, rs);
            cmp++; if ({err, result, cout, ovf, zero} !== {1'b1, 8'd0, 3'b000}) begin errs++;
                $display("FAIL illegal%0d_out: got err=%b res=%0d c=%b v=%b z=%b want 1/0/0/0/0", i, err, result, cout, ovf, zero); end
            cmp++; if (lat != 1) begin errs++; $display("FAIL illegal%0d_latency: got %0d want 1", i, lat); end
            model(OP_ADC, 8'd0, 8'd0, 1'b0, er, ec, ez, ev, ee);
            run_op(OP_ADC, 8'd0, 8'd0, 1'b0, lat, rs);
            cmp++; if (result !== 8'd1) begin errs++; $display("FAIL illegal%0d_carry_kept: got %0d want 1", i, result); end
        end
    endtask

    task automatic test_mul;
        logic [7:0] er; logic ec, ez, ev, ee;
        int lat; bit rs;
        model(OP_MUL, 8'd15, 8'd17, 1'b0, er, ec, ez, ev, ee);
        run_op(OP_MUL, 8'd15, 8'd17, 1'b0, lat, rs);
        cmp++; if ({result, cout} !== {8'd255, 1'b0}) begin errs++; $display("FAIL mul15x17: got %0d/%b want 255/0", result, cout); end
        cmp++; if (lat != 9) begin errs++; $display("FAIL mul_latency: got %0d want 9", lat); end
        cmp++; if (rs !== 1'b0) begin errs++; $display("FAIL mul_in_ready_busy: got %b want 0", rs); end
        model(OP_MUL, 8'd16, 8'd16, 1'b0, er, ec, ez, ev, ee);
        run_op(OP_MUL, 8'd16, 8'd16, 1'b0, lat, rs);
        cmp++; if ({result, cout, zero, ovf, err} !== {8'd0, 1'b1, 1'b1, 2'b00}) begin errs++;
            $display("FAIL mul16x16: got %0d c=%b z=%b v=%b e=%b want 0/1/1/0/0", result, cout, zero, ovf, err); end
        model(OP_ADC, 8'd0, 8'd0, 1'b0, er, ec, ez, ev, ee);
        run_op(OP_ADC, 8'd0, 8'd0, 1'b0, lat, rs);
        cmp++; if (result !== 8'd1) begin errs++; $display("FAIL mul_sets_carry: got %0d want 1", result); end
    endtask

    task automatic test_backpressure;
        logic [7:0] er; logic ec, ez, ev, ee;
        int lat; bit rs;
        @(posedge clk); #1;
        out_ready = 1'b0;
        model(OP_ADD, 8'd37, 8'd45, 1'b0, er, ec, ez, ev, ee);
        run_op(OP_ADD, 8'd37, 8'd45, 1'b0, lat, rs);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; op = OP_XOR; a = 8'($urandom); b = 8'($urandom);
            @(posedge clk); #1;
            cmp++; if ({out_valid, in_ready, result, cout, zero, ovf, err} !== {2'b10, 8'd82, 4'b0000}) begin errs++;
                $display("FAIL hold%0d: got v=%b r=%b res=%0d flags=%b want 1/0/82/0000", i, out_valid, in_ready, result, {cout, zero, ovf, err}); end
        end
        out_ready = 1'b1;
        in_valid = 1'b1; op = OP_OR; a = 8'h0F; b = 8'hF0; cin = 1'b0;
        model(OP_OR, 8'h0F, 8'hF0, 1'b0, er, ec, ez, ev, ee);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cmp++; if ({out_valid, result} !== {1'b1, er}) begin errs++; $display("FAIL b2b_release: got %b/%0d want 1/%0d", out_valid, result, er); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] er; logic ec, ez, ev, ee;
        logic [15:0] o;
        int idx, n;
        for (int k = 0; k < 10; k++) begin
            idx = $urandom_range(0, 10);
            if (idx == 10) idx = 11;
            o = 16'(1) << idx;
            in_valid = 1'b1; op = o; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            model(o, a, b, cin, er, ec, ez, ev, ee);
            @(posedge clk); #1;
            cmp++; if ({out_valid, result, cout, zero, ovf} !== {1'b1, er, ec, ez, ev}) begin errs++;
                $display("FAIL stream%0d op%0d: got v=%b %0d c=%b z=%b o=%b want 1 %0d c=%b z=%b o=%b",
                         k, idx, out_valid, result, cout, zero, ovf, er, ec, ez, ev); end
        end
        in_valid = 1'b0;
        n = 10;
        while (out_valid && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        cmp++; if (n != 11) begin errs++; $display("FAIL stream_cycles: got %0d want 11", n); end
    endtask

    task automatic test_random;
        logic [7:0] er; logic ec, ez, ev, ee;
        logic [15:0] o;
        logic [7:0] x, y;
        logic ci;
        int sel, lat; bit rs;
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 13);
            o = (sel < 12) ? (16'(1) << sel) : 16'($urandom);
            x = 8'($urandom); y = 8'($urandom); ci = 1'($urandom);
            model(o, x, y, ci, er, ec, ez, ev, ee);
            run_op(o, x, y, ci, lat, rs);
            cmp++; if ({result, cout, zero, ovf, err} !== {er, ec, ez, ev, ee}) begin errs++;
                $display("FAIL rand%0d op=%h a=%0d b=%0d: got %0d c=%b z=%b v=%b e=%b want %0d c=%b z=%b v=%b e=%b",
                         i, o, x, y, result, cout, zero, ovf, err, er, ec, ez, ev, ee); end
            cmp++; if (lat != ((o == OP_MUL) ? 9 : 1)) begin errs++; $display("FAIL rand%0d_latency: got %0d", i, lat); end
        end
    endtask

    task automatic test_reset_mid_mul;
        logic [7:0] er; logic ec, ez, ev, ee;
        int lat; bit rs;
        model(OP_ADD, 8'd200, 8'd100, 1'b0, er, ec, ez, ev, ee);
        run_op(OP_ADD, 8'd200, 8'd100, 1'b0, lat, rs);
        in_valid = 1'b1; op = OP_MUL; a = 8'd99; b = 8'd77; cin = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        cmp++; if ({out_valid, result, cout, zero, ovf, err} !== 13'd0) begin errs++;
            $display("FAIL midmul_reset: got v=%b res=%0d c=%b z=%b o=%b e=%b want all 0", out_valid, result, cout, zero, ovf, err); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_carry = 1'b0;
        model(OP_ADD, 8'd1, 8'd1, 1'b0, er, ec, ez, ev, ee);
        run_op(OP_ADD, 8'd1, 8'd1, 1'b0, lat, rs);
        cmp++; if ({result, lat} !== {8'd2, 32'd1}) begin errs++; $display("FAIL post_reset_add: got %0d lat %0d want 2 lat 1", result, lat); end
        model(OP_ADC, 8'd0, 8'd0, 1'b0, er, ec, ez, ev, ee);
        run_op(OP_ADC, 8'd0, 8'd0, 1'b0, lat, rs);
        cmp++; if (result !== 8'd0) begin errs++; $display("FAIL post_reset_carry: got %0d want 0", result); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_carry_chain();
        test_illegal();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 8-bit one-hot-opcode ALU.
- Accepts operations through a valid/ready handshake and registers every result.
- Adds zero and signed-overflow flags, a persistent carry flag for chained add-with-carry, and a multi-cycle shift-and-add multiply.
- Sits between the operand/decode stage and the writeback stage of the datapath.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
OPW, 16, width of the one-hot opcode bus (>=12)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request valid
in_ready  output  1  block can accept an operation this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  serial-in bit for shift operations
op  input  OPW  one-hot opcode
out_valid  output  1  result registers hold an unconsumed result
out_ready  input  1  downstream accepts the result
result  output  WIDTH  registered result
cout  output  1  carry, borrow or shifted-out bit
zero  output  1  result == 0
ovf  output  1  signed overflow
err  output  1  illegal opcode flag for this result

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; result=0; cout=0; zero=0; ovf=0; err=0; out_valid=0; carry flag=0; multiply counter=0.
  - Effective immediately, including mid-multiply; the partial product is discarded.
- Opcodes (one-hot bit index):
  - 0 ADD: a+b; cout=carry out.
  - 1 SUB: a-b mod 2^WIDTH; cout=1 iff a<b unsigned (borrow).
  - 2 SHL: {a[W-2:0],cin}; cout=a[W-1].
  - 3 SHR: {cin,a[W-1:1]}; cout=a[0].
  - 4 ROL: {a[W-2:0],a[W-1]}; cout=a[W-1].
  - 5 ROR: {a[0],a[W-1:1]}; cout=a[0].
  - 6 NOT: ~a.
  - 7 AND, 8 OR, 9 XOR: a op b.
  - 10 MUL: low WIDTH bits of a*b unsigned; cout=1 iff the upper WIDTH bits of the full product are nonzero.
  - 11 ADC: a+b+carry flag; cout=carry out.
  - For ops 6–9, cout=0.
- Flags:
  - ovf: signed overflow for ADD, SUB and ADC; 0 for all other ops.
  - zero: result==0, for every legal op.
  - Carry flag register: updated with cout on completion of ops 0–5, 10 and 11; unchanged by ops 6–9 and by illegal ops.
- Illegal opcode: op==0, more than one bit set, or any bit >=12 set.
  - Completes as a single-cycle op with result=0, err=1, cout=0, ovf=0, zero=0.
- States: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid:
    - MUL: latch operands and go to BUSY with counter=0.
    - Any other op (legal or illegal): register outputs at this edge and go to DONE.
  - BUSY: in_ready=0. One shift-and-add step per cycle for WIDTH cycles. At the edge where counter reaches WIDTH-1, register the outputs and go to DONE.
  - DONE: out_valid=1; outputs are held stable while out_ready=0. in_ready=out_ready.
    - out_ready=1 and in_valid=1: the result is consumed and the new op is accepted in the same cycle (back-to-back, same rules as IDLE).
    - out_ready=1 and in_valid=0: go to IDLE.
- Latency (accept edge to out_valid=1): 1 cycle for single-cycle ops; WIDTH+1 cycles for MUL.
- Throughput: one single-cycle op per cycle while out_ready=1.
- Ignored inputs: in_valid while in_ready=0; a, b, op and cin while BUSY.
- out_valid deasserts the cycle after the handshake unless a new op was accepted on the same edge.

Test Plan:
- WIDTH=8. ADD 100+100 -> result=200, cout=0, ovf=1, zero=0, 1-cycle latency. SUB 50-100 -> result=206, cout=1, ovf=0.
- SHL a=129, cin=1 -> result=0000_0011, cout=1. SHR a=129, cin=0 -> result=0100_0000, cout=1. ROR a=129 -> result=1100_0000, cout=1. XOR 85^211 -> result=134, cout=0.
- Carry chain: ADD 200+100 (result=44, cout=1), then ADC 0+0 -> result=1, cout=0. A following AND leaves the carry flag at 0.
- MUL 15*17 -> result=255, cout=0, out_valid exactly 9 cycles after accept, in_ready=0 throughout. MUL 16*16 -> result=0, cout=1, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles -> result and flags are stable and in_valid is ignored. Raise out_ready with in_valid=1 -> back-to-back accept; streaming 10 single-cycle ops with out_ready=1 completes in 11 cycles.
- op=0, op=0x0003 and op=0x1000 -> err=1, result=0, carry flag unchanged. Asserting rst_n=0 mid-MUL (counter=4) -> all outputs 0 immediately, then a fresh ADD 1+1 -> result=2.
